// File: rtl/sv_mm_ctrl_if.sv
// rtl/sv_mm_ctrl_if.sv - operand request / result handshake bundle for sv_mm_ctrl
interface sv_mm_ctrl_if #(
  parameter int DATA_WIDTH = 512
);
  logic                  req_i;
  logic                  ready_o;
  logic [DATA_WIDTH-1:0] q_i;
  logic [DATA_WIDTH-1:0] x_i;
  logic [DATA_WIDTH-1:0] y_i;
  logic                  busy_o;
  logic                  res_valid_o;
  logic                  res_ready_i;
  logic [DATA_WIDTH-1:0] res_o;

  // operand scheduler side
  modport master (
    output req_i, q_i, x_i, y_i, res_ready_i,
    input  ready_o, busy_o, res_valid_o, res_o
  );

  // sequencer side
  modport slave (
    input  req_i, q_i, x_i, y_i, res_ready_i,
    output ready_o, busy_o, res_valid_o, res_o
  );
endinterface

// File: rtl/sv_mm_ctrl.sv
// rtl/sv_mm_ctrl.sv - Montgomery multiply sequencer with its unrolled round core
module sv_me #(
  parameter int DATA_WIDTH     = 512,
  parameter int ROUND_PER_TACT = 1
) (
  input  logic [DATA_WIDTH-1:0] q_i,
  input  logic [DATA_WIDTH-1:0] x_i,
  input  logic [DATA_WIDTH-1:0] y_i,
  input  logic [DATA_WIDTH+1:0] z_i,
  output logic [DATA_WIDTH-1:0] y_o,
  output logic [DATA_WIDTH+1:0] z_o
);
  // z stays below 2q, so z + x + q < 4q fits in DATA_WIDTH+2 bits without overflow
  logic [DATA_WIDTH+1:0] zt;
  logic [DATA_WIDTH+1:0] t;
  logic [DATA_WIDTH-1:0] yt;

  // ROUND_PER_TACT chained radix-2 Montgomery rounds, combinational
  always_comb begin
    zt = z_i;
    yt = y_i;
    t  = '0;
    for (int r = 0; r < ROUND_PER_TACT; r++) begin
      t = zt + (yt[0] ? {2'b00, x_i} : '0);
      if (t[0]) begin
        t = t + {2'b00, q_i};
      end
      zt = t >> 1;
      yt = yt >> 1;
    end
    z_o = zt;
    y_o = yt;
  end
endmodule

module sv_mm_ctrl #(
  parameter int DATA_WIDTH     = 512,
  parameter int ROUND_PER_TACT = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  sv_mm_ctrl_if.slave  bus
);
  localparam int N  = DATA_WIDTH / ROUND_PER_TACT;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  if ((DATA_WIDTH % ROUND_PER_TACT) != 0) begin : g_width_check
    $error("sv_mm_ctrl: DATA_WIDTH must be a multiple of ROUND_PER_TACT");
  end

  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] q_r;
  logic [DATA_WIDTH-1:0] x_r;
  logic [DATA_WIDTH-1:0] y_r;
  logic [DATA_WIDTH+1:0] z_r;
  logic [DATA_WIDTH-1:0] res_r;

  logic [DATA_WIDTH-1:0] y_nxt;
  logic [DATA_WIDTH+1:0] z_nxt;
  logic                  z_ge_q;
  logic [DATA_WIDTH-1:0] z_minus_q;

  sv_me #(
    .DATA_WIDTH     (DATA_WIDTH),
    .ROUND_PER_TACT (ROUND_PER_TACT)
  ) u_me (
    .q_i (q_r),
    .x_i (x_r),
    .y_i (y_r),
    .z_i (z_r),
    .y_o (y_nxt),
    .z_o (z_nxt)
  );

  // final correction: compare at full width, the low bits of the difference are all we keep
  assign z_ge_q    = (z_r >= {2'b00, q_r});
  assign z_minus_q = z_r[DATA_WIDTH-1:0] - q_r;

  // accept operands, iterate N tacts, reduce once, then hold the result until taken
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      cnt   <= '0;
      q_r   <= '0;
      x_r   <= '0;
      y_r   <= '0;
      z_r   <= '0;
      res_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_i) begin
            q_r   <= bus.q_i;
            x_r   <= bus.x_i;
            y_r   <= bus.y_i;
            z_r   <= '0;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          y_r <= y_nxt;
          z_r <= z_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          res_r <= z_ge_q ? z_minus_q : z_r[DATA_WIDTH-1:0];
          state <= S_DONE;
        end
        S_DONE: begin
          if (bus.res_ready_i) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready_o     = (state == S_IDLE);
  assign bus.busy_o      = (state == S_RUN) || (state == S_FIX);
  assign bus.res_valid_o = (state == S_DONE);
  assign bus.res_o       = res_r;
endmodule

// File: tb/tb_sv_mm_ctrl.sv
// tb/tb_sv_mm_ctrl.sv - self-checking bench for sv_mm_ctrl at 8-bit and 64-bit widths
module tb_sv_mm_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;

  sv_mm_ctrl_if #(.DATA_WIDTH(8))  ifa();
  sv_mm_ctrl_if #(.DATA_WIDTH(8))  ifb();
  sv_mm_ctrl_if #(.DATA_WIDTH(64)) ifc();

  sv_mm_ctrl #(.DATA_WIDTH(8),  .ROUND_PER_TACT(1)) dut_a (.clk_i(clk), .rst_i(rst_a), .bus(ifa.slave));
  sv_mm_ctrl #(.DATA_WIDTH(8),  .ROUND_PER_TACT(2)) dut_b (.clk_i(clk), .rst_i(rst_b), .bus(ifb.slave));
  sv_mm_ctrl #(.DATA_WIDTH(64), .ROUND_PER_TACT(1)) dut_c (.clk_i(clk), .rst_i(rst_c), .bus(ifc.slave));

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // x*y*2^-64 mod q: reduce the plain product, then halve modulo q sixty-four times
  function automatic logic [63:0] ref_mont64(input logic [63:0] q, input logic [63:0] x, input logic [63:0] y);
    logic [127:0] r;
    r = ({64'b0, x} * {64'b0, y}) % {64'b0, q};
    for (int i = 0; i < 64; i++) begin
      r = r[0] ? ((r + {64'b0, q}) >> 1) : (r >> 1);
    end
    return r[63:0];
  endfunction

  task automatic op_a(input logic [7:0] q, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] exp, input logic hold_ready, input string tag);
    int lat;
    int busy_n;
    @(negedge clk);
    chk({tag, " ready_before"}, ifa.ready_o, 1);
    ifa.req_i = 1'b1; ifa.q_i = q; ifa.x_i = x; ifa.y_i = y; ifa.res_ready_i = hold_ready;
    @(negedge clk);
    ifa.req_i = 1'b0; ifa.q_i = 8'($urandom); ifa.x_i = 8'($urandom); ifa.y_i = 8'($urandom);
    lat = 0; busy_n = 0;
    while (ifa.res_valid_o !== 1'b1 && lat < 200) begin
      busy_n += int'(ifa.busy_o);
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, 9);
    chk({tag, " busy_cycles"}, busy_n, 9);
    chk({tag, " res"}, ifa.res_o, exp);
    ifa.res_ready_i = 1'b1;
    @(negedge clk);
    chk({tag, " valid_one_cycle"}, ifa.res_valid_o, 0);
    chk({tag, " ready_after"}, ifa.ready_o, 1);
    ifa.res_ready_i = 1'b0;
  endtask

  initial begin
    logic [63:0] q64, x64, y64, e64;
    int lat, stall;

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    ifa.req_i = 0; ifa.q_i = 0; ifa.x_i = 0; ifa.y_i = 0; ifa.res_ready_i = 0;
    ifb.req_i = 0; ifb.q_i = 0; ifb.x_i = 0; ifb.y_i = 0; ifb.res_ready_i = 0;
    ifc.req_i = 0; ifc.q_i = 0; ifc.x_i = 0; ifc.y_i = 0; ifc.res_ready_i = 0;
    repeat (2) @(negedge clk);
    chk("rst ready", ifa.ready_o, 1);
    chk("rst busy", ifa.busy_o, 0);
    chk("rst valid", ifa.res_valid_o, 0);
    chk("rst res", ifa.res_o, 0);
    chk("rst c valid", ifc.res_valid_o, 0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // directed vectors, result held with ready high from the start
    op_a(8'd13, 8'd5,  8'd7,  8'd1, 1'b1, "a_5x7");
    op_a(8'd13, 8'd1,  8'd1,  8'd3, 1'b0, "a_1x1");
    op_a(8'd13, 8'd12, 8'd12, 8'd3, 1'b1, "a_12x12");
    op_a(8'd13, 8'd0,  8'd9,  8'd0, 1'b0, "a_0x9");
    op_a(8'd13, 8'd9,  8'd0,  8'd0, 1'b1, "a_9x0");

    // backpressure: 20 stalled cycles with stray requests
    @(negedge clk);
    ifa.req_i = 1'b1; ifa.q_i = 8'd13; ifa.x_i = 8'd5; ifa.y_i = 8'd7; ifa.res_ready_i = 1'b0;
    @(negedge clk);
    ifa.req_i = 1'b0;
    lat = 0;
    while (ifa.res_valid_o !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("bp latency", lat, 9);
    for (int i = 0; i < 20; i++) begin
      ifa.req_i = 1'(i & 1);
      @(negedge clk);
      chk("bp valid", ifa.res_valid_o, 1);
      chk("bp res", ifa.res_o, 1);
      chk("bp ready", ifa.ready_o, 0);
    end
    ifa.req_i = 1'b0; ifa.res_ready_i = 1'b1;
    @(negedge clk);
    chk("bp release ready", ifa.ready_o, 1);
    chk("bp release valid", ifa.res_valid_o, 0);
    ifa.res_ready_i = 1'b0;

    // reset on the 4th RUN cycle aborts the operation
    @(negedge clk);
    ifa.req_i = 1'b1; ifa.q_i = 8'd13; ifa.x_i = 8'd12; ifa.y_i = 8'd12; ifa.res_ready_i = 1'b1;
    @(negedge clk);
    ifa.req_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort busy_before", ifa.busy_o, 1);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    chk("abort ready", ifa.ready_o, 1);
    chk("abort busy", ifa.busy_o, 0);
    chk("abort valid", ifa.res_valid_o, 0);
    chk("abort res", ifa.res_o, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort no_valid", ifa.res_valid_o, 0);
    end
    ifa.res_ready_i = 1'b0;
    op_a(8'd13, 8'd5, 8'd7, 8'd1, 1'b0, "a_after_abort");

    // two rounds per tact
    @(negedge clk);
    ifb.req_i = 1'b1; ifb.q_i = 8'd13; ifb.x_i = 8'd5; ifb.y_i = 8'd7; ifb.res_ready_i = 1'b0;
    @(negedge clk);
    ifb.req_i = 1'b0; ifb.x_i = 8'd3;
    lat = 0;
    while (ifb.res_valid_o !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("b latency", lat, 5);
    chk("b res", ifb.res_o, 1);
    ifb.res_ready_i = 1'b1;
    @(negedge clk);
    chk("b ready_after", ifb.ready_o, 1);
    ifb.res_ready_i = 1'b0;

    // randomized 64-bit operations against the arithmetic model
    for (int n = 0; n < 1000; n++) begin
      q64 = {$urandom, $urandom} | 64'd1;
      if (q64 < 64'd3) q64 = 64'd3;
      x64 = {$urandom, $urandom} % q64;
      y64 = {$urandom, $urandom} % q64;
      if ($urandom_range(0, 15) == 0) x64 = 64'd0;
      if ($urandom_range(0, 15) == 0) y64 = 64'd0;
      e64 = ref_mont64(q64, x64, y64);
      stall = int'($urandom_range(0, 3));
      @(negedge clk);
      chk("c ready_before", ifc.ready_o, 1);
      ifc.req_i = 1'b1; ifc.q_i = q64; ifc.x_i = x64; ifc.y_i = y64;
      ifc.res_ready_i = (stall == 0);
      @(negedge clk);
      ifc.req_i = 1'b0; ifc.q_i = {$urandom, $urandom}; ifc.x_i = {$urandom, $urandom}; ifc.y_i = {$urandom, $urandom};
      lat = 0;
      while (ifc.res_valid_o !== 1'b1 && lat < 300) begin
        @(negedge clk);
        lat++;
      end
      chk("c latency", lat, 65);
      chk("c res", ifc.res_o, e64);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        chk("c stall res", ifc.res_o, e64);
      end
      ifc.res_ready_i = 1'b1;
      @(negedge clk);
      chk("c valid_one_cycle", ifc.res_valid_o, 0);
      ifc.res_ready_i = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sv_mm_ctrl.md
# sv_mm_ctrl

Sequencer for the unrolled Montgomery round core `sv_me`. It captures one operand set (modulus, multiplicand, multiplier) and iterates `sv_me` over DATA_WIDTH/ROUND_PER_TACT clock cycles. It then applies the final conditional subtraction and presents the reduced product through a valid/ready result port. It sits between the signature engine's operand scheduler and the modular-arithmetic datapath.

## Interface
- DATA_WIDTH, 512: operand and modulus width in bits.
- ROUND_PER_TACT, 1: Montgomery rounds per clock, passed to `sv_me`. DATA_WIDTH must be an integer multiple of it; an elaboration-time check fails otherwise.
- clk_i  in  1: single clock; all state updates on rising edge.
- rst_i  in  1: reset, synchronous, active-high.
- req_i  in  1: operand set offered.
- ready_o  out  1: block can accept; high only in IDLE.
- q_i  in  DATA_WIDTH: modulus; odd, q ≥ 3.
- x_i  in  DATA_WIDTH: multiplicand, x < q.
- y_i  in  DATA_WIDTH: multiplier, y < q.
- busy_o  out  1: high in RUN and FIX.
- res_valid_o  out  1: result available.
- res_ready_i  in  1: consumer takes result.
- res_o  out  DATA_WIDTH: x·y·2^(−DATA_WIDTH) mod q, fully reduced (< q).

## Operation
- States: IDLE, RUN, FIX, DONE. Encoding is free.
- N = DATA_WIDTH/ROUND_PER_TACT, the iteration count.
- **IDLE**
  - ready_o=1.
  - On req_i=1: register q_i, x_i and y_i into q_r, x_r and y_r.
  - Clear z_r (DATA_WIDTH+2 bits) to 0 and clear the round counter.
  - Go to RUN.
- **RUN**
  - Each cycle: y_r←y_o and z_r←z_o of the `sv_me` instance, whose inputs are q_r, x_r, y_r and z_r. The counter increments.
  - After the N-th update, go to FIX.
  - Each round is z←(z + y[0]·x + odd(z + y[0]·x)·q)/2, followed by y←y>>1.
  - Invariant: z < 2q at all times, so z_r needs no wider than DATA_WIDTH+2 bits.
- **FIX**
  - If z_r ≥ q, res_r←(z_r−q)[DATA_WIDTH−1:0]; else res_r←z_r[DATA_WIDTH−1:0].
  - Comparison and subtraction are done at DATA_WIDTH+2 bits. This takes one cycle.
  - Go to DONE.
- **DONE**
  - res_valid_o=1 and res_o=res_r, held stable until res_ready_i=1.
  - On res_ready_i=1, go to IDLE.
- req_i is ignored in RUN, FIX and DONE; ready_o=0 there. Operand inputs may change freely after acceptance.
- res_ready_i outside DONE is ignored.

## Timing
- **Reset values**
  - State IDLE.
  - ready_o=1, busy_o=0, res_valid_o=0.
  - res_o=0, and res_r, z_r, y_r, x_r and q_r all 0.
- **Acceptance**
  - A request is accepted at rising edge A when req_i=1 and the state is IDLE.
- **Latency**
  - RUN updates occur on edges A+1..A+N.
  - FIX occurs on edge A+N+1.
  - res_valid_o is high from the cycle after edge A+N+1, i.e. N+1 cycles after acceptance.
- **Completion and throughput**
  - The result handshake completes on the edge where res_valid_o=1 and res_ready_i=1. ready_o rises in the following cycle.
  - Minimum request-to-request spacing is N+3 cycles.
- **Boundary conditions**
  - rst_i during RUN or FIX aborts the operation: next cycle IDLE, outputs at reset values, and no res_valid_o for the aborted operation.
  - rst_i in DONE discards the unread result.
  - rst_i has priority over req_i and res_ready_i in the same cycle.
  - x=0 or y=0 yields res_o=0.
  - z_r=q exactly at FIX yields res_o=0.
  - res_ready_i held high continuously: res_valid_o is high for exactly one cycle per operation.

## Test plan
- DATA_WIDTH=8, ROUND_PER_TACT=1; q=13, x=5, y=7 -> res_o=1. res_valid_o rises 9 cycles after acceptance. busy_o is high for exactly 9 cycles.
- Same configuration; x=1, y=1 -> 3. x=12, y=12 -> 3. x=0, y=9 -> 0.
- DATA_WIDTH=8, ROUND_PER_TACT=2; q=13, x=5, y=7 -> res_o=1, with res_valid_o 5 cycles after acceptance.
- Backpressure: hold res_ready_i=0 for 20 cycles after valid. res_o and res_valid_o stay stable, req_i pulses are ignored and ready_o stays 0. Release -> IDLE next cycle.
- Assert rst_i on the 4th RUN cycle -> next cycle ready_o=1, busy_o=0, res_valid_o=0. A following request q=13, x=5, y=7 completes with res_o=1.
- Randomized: DATA_WIDTH=64, odd q, random x,y < q. Check against the reference model x·y·2^(−64) mod q over 1000 operations with random res_ready_i stalls.
